morph_3x3_filter: RTL and testbench

Parametrised 3×3 grey-scale morphology stage: takes three vertically aligned row taps from the upstream line buffer, forms a 3×3 window per pixel, and outputs the per-channel maximum (dilate) or minimum (erode) over a cross- or square-shaped structuring element. Left and right image borders use edge replication, and each line is flushed explicitly, so every input pixel yields exactly one output pixel. Sits between the line buffer and the output packer in the dilate/erode pipeline.

---
 rtl/morph_pkg.sv | 15 +
 rtl/morph_if.sv | 9 +
 rtl/morph_reduce.sv | 23 ++
 rtl/morph_3x3_filter.sv | 81 ++++++++
 tb/tb_morph_3x3_filter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/morph_pkg.sv
// morph_pkg: shared FSM states, mode/shape constants and channel compare helper
package morph_pkg;
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  localparam logic MODE_ERODE = 1'b1;
  localparam logic SHAPE_SQUARE = 1'b1;
  localparam logic [8:0] CROSS_MASK = 9'b010_111_010;
  localparam logic [8:0] SQUARE_MASK = 9'b111_111_111;
  localparam int SEL_W = 32;
  function automatic logic [SEL_W-1:0] ch_sel(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b, input logic mode);
    return ((mode == MODE_ERODE) ? (b < a) : (b > a)) ? b : a;
  endfunction
  function automatic logic [8:0] tap_mask(input logic shape);
    return (shape == SHAPE_SQUARE) ? SQUARE_MASK : CROSS_MASK;
  endfunction
endpackage

// File: rtl/morph_if.sv
// morph_if: row-tap input and filtered-pixel output bundle
interface morph_if #(parameter int PIX_W = 24);
  logic valid_in, eol_in, mode_erode, shape_square, in_ready, valid_out, eol_out;
  logic [PIX_W-1:0] row_top, row_mid, row_bot, dout;
  modport master(output valid_in, eol_in, row_top, row_mid, row_bot, mode_erode, shape_square,
                 input in_ready, valid_out, eol_out, dout);
  modport slave(input valid_in, eol_in, row_top, row_mid, row_bot, mode_erode, shape_square,
                output in_ready, valid_out, eol_out, dout);
endinterface

// File: rtl/morph_reduce.sv
// morph_reduce: per-channel masked min/max over a 3x3 window
module morph_reduce
  import morph_pkg::*;
#(
  parameter int CH_W = 8,
  parameter int CHANNELS = 3,
  localparam int PIX_W = CH_W * CHANNELS
) (
  input  logic [PIX_W-1:0] win [9],
  input  logic [8:0]       mask,
  input  logic             erode,
  output logic [PIX_W-1:0] dout
);
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [CH_W-1:0] acc;
    always_comb begin
      acc = erode ? '1 : '0;
      for (int i = 0; i < 9; i++)
        acc = mask[i] ? CH_W'(ch_sel(SEL_W'(acc), SEL_W'(win[i][k*CH_W +: CH_W]), erode)) : acc;
    end
    assign dout[k*CH_W +: CH_W] = acc;
  end
endmodule

// File: rtl/morph_3x3_filter.sv
// morph_3x3_filter: 3x3 dilate/erode with edge replication and per-line flush
module morph_3x3_filter
  import morph_pkg::*;
#(
  parameter int CH_W = 8,
  parameter int CHANNELS = 3,
  parameter int PIC_WIDTH = 250
) (
  input logic  clk,
  input logic  rst,
  morph_if.slave bus
);
  localparam int PIX_W = CH_W * CHANNELS;
  localparam int CNT_W = $clog2(PIC_WIDTH + 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [PIX_W-1:0] rin [3];
  logic [PIX_W-1:0] sl [3];
  logic [PIX_W-1:0] sc [3];
  logic [PIX_W-1:0] sr [3];
  logic [PIX_W-1:0] win [9];
  logic [PIX_W-1:0] red;
  logic acc_in, last_in, pend, pend_eol, mode_q, shape_q;
  assign rin[0] = bus.row_top;
  assign rin[1] = bus.row_mid;
  assign rin[2] = bus.row_bot;
  assign bus.in_ready = state != FLUSH;
  assign acc_in = bus.valid_in && bus.in_ready;
  assign last_in = bus.eol_in || cnt == CNT_W'(PIC_WIDTH - 1);
  always_comb begin
    state_nx = state == FLUSH ? FILL : acc_in ? (last_in ? FLUSH : RUN) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt <= '0;
      pend <= 1'b0;
      pend_eol <= 1'b0;
      mode_q <= 1'b0;
      shape_q <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.eol_out <= 1'b0;
      bus.dout <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == FLUSH ? '0 : acc_in ? cnt + 1'b1 : cnt;
      pend <= (acc_in && state == RUN) || state == FLUSH;
      pend_eol <= state == FLUSH;
      bus.valid_out <= pend;
      bus.eol_out <= pend_eol;
      if (pend) bus.dout <= red;
      if (acc_in && state == FILL) begin
        mode_q <= bus.mode_erode;
        shape_q <= bus.shape_square;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (state == FLUSH) begin
        sl[i] <= sc[i];
        sc[i] <= sr[i];
      end else if (acc_in) begin
        sl[i] <= sc[i];
        sc[i] <= state == FILL ? rin[i] : sr[i];
        sr[i] <= rin[i];
      end
    end
  end
  for (genvar j = 0; j < 3; j++) begin : g_win
    assign win[3*j]   = sl[j];
    assign win[3*j+1] = sc[j];
    assign win[3*j+2] = sr[j];
  end
  morph_reduce #(.CH_W(CH_W), .CHANNELS(CHANNELS)) u_reduce (
    .win  (win),
    .mask (tap_mask(shape_q)),
    .erode(mode_q),
    .dout (red)
  );
endmodule

// File: tb/tb_morph_3x3_filter.sv
// tb_morph_3x3_filter: directed self-checking bench for the 3x3 morphology stage
module tb_morph_3x3_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0, eol_in = 1'b0, mode_erode = 1'b0, shape_square = 1'b0, sel4 = 1'b0;
  logic [23:0] top = '0, mid = '0, bot = '0;
  logic [23:0] qd[$];
  logic [23:0] qd4[$];
  logic qe[$];
  logic qe4[$];
  logic rdy;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  morph_if #(.PIX_W(24)) b();
  morph_if #(.PIX_W(24)) b4();
  assign b.valid_in = valid_in && !sel4;
  assign b4.valid_in = valid_in && sel4;
  assign b.eol_in = eol_in;
  assign b4.eol_in = eol_in;
  assign b.row_top = top;
  assign b4.row_top = top;
  assign b.row_mid = mid;
  assign b4.row_mid = mid;
  assign b.row_bot = bot;
  assign b4.row_bot = bot;
  assign b.mode_erode = mode_erode;
  assign b4.mode_erode = mode_erode;
  assign b.shape_square = shape_square;
  assign b4.shape_square = shape_square;
  assign rdy = sel4 ? b4.in_ready : b.in_ready;
  morph_3x3_filter #(.CH_W(8), .CHANNELS(3), .PIC_WIDTH(250)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  morph_3x3_filter #(.CH_W(8), .CHANNELS(3), .PIC_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  always @(negedge clk) begin
    if (b.valid_out) begin
      qd.push_back(b.dout);
      qe.push_back(b.eol_out);
    end
    if (b4.valid_out) begin
      qd4.push_back(b4.dout);
      qe4.push_back(b4.eol_out);
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic px(input logic [23:0] t, input logic [23:0] m, input logic [23:0] bt, input logic e);
    bit done = 0;
    valid_in = 1'b1;
    eol_in = e;
    top = t;
    mid = m;
    bot = bt;
    for (int i = 0; i < 10 && !done; i++) begin
      done = rdy;
      @(negedge clk);
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL px_accept: in_ready stayed 0 for 10 cycles, required 1");
    end
    valid_in = 1'b0;
    eol_in = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    n_chk++; if (b.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", b.valid_out); end
    n_chk++; if (b.eol_out !== 1'b0) begin n_fail++; $display("FAIL reset_eol got %b want 0", b.eol_out); end
    n_chk++; if (b.dout !== 24'h0) begin n_fail++; $display("FAIL reset_dout got %h want 000000", b.dout); end
    n_chk++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", b.in_ready); end
    n_chk++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready4 got %b want 1", b4.in_ready); end
  endtask
  task automatic test_dilate_cross();
    logic [23:0] ed [5] = '{24'd20, 24'd30, 24'd40, 24'd50, 24'd50};
    logic [23:0] g;
    logic ge;
    sel4 = 1'b0; mode_erode = 1'b0; shape_square = 1'b0;
    qd.delete(); qe.delete();
    for (int i = 0; i < 5; i++) px(24'h0, 24'((i + 1) * 10), 24'h0, i == 4);
    n_chk++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL dc_ready_flush got %b want 0", b.in_ready); end
    idle(1);
    n_chk++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL dc_ready_after got %b want 1", b.in_ready); end
    idle(5);
    n_chk++; if (qd.size() != 5) begin n_fail++; $display("FAIL dc_count got %0d want 5", qd.size()); end
    for (int i = 0; i < 5; i++) begin
      g = i < qd.size() ? qd[i] : 24'hx;
      ge = i < qe.size() ? qe[i] : 1'bx;
      n_chk++; if (g !== ed[i]) begin n_fail++; $display("FAIL dc_dout[%0d] got %h want %h", i, g, ed[i]); end
      n_chk++; if (ge !== (i == 4)) begin n_fail++; $display("FAIL dc_eol[%0d] got %b want %b", i, ge, i == 4); end
    end
  endtask
  task automatic test_channels();
    logic [23:0] ed [3] = '{24'h20F0F0, 24'h20F0F0, 24'h20F010};
    logic [23:0] g;
    sel4 = 1'b0; mode_erode = 1'b0; shape_square = 1'b0;
    qd.delete(); qe.delete();
    px(24'h0, 24'h2010F0, 24'h0, 1'b0);
    px(24'h0, 24'h20F010, 24'h0, 1'b0);
    px(24'h0, 24'h000000, 24'h0, 1'b1);
    idle(6);
    n_chk++; if (qd.size() != 3) begin n_fail++; $display("FAIL ch_count got %0d want 3", qd.size()); end
    for (int i = 0; i < 3; i++) begin
      g = i < qd.size() ? qd[i] : 24'hx;
      n_chk++; if (g !== ed[i]) begin n_fail++; $display("FAIL ch_dout[%0d] got %h want %h", i, g, ed[i]); end
    end
  endtask
  task automatic test_back_to_back_erode();
    logic [23:0] ed [6] = '{24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'hFFFFFF};
    logic [23:0] g;
    logic ge;
    sel4 = 1'b0; mode_erode = 1'b1;
    qd.delete(); qe.delete();
    for (int l = 0; l < 2; l++) begin
      shape_square = l == 0;
      for (int i = 0; i < 3; i++) px(i == 0 ? 24'h0 : 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, i == 2);
    end
    idle(6);
    n_chk++; if (qd.size() != 6) begin n_fail++; $display("FAIL er_count got %0d want 6", qd.size()); end
    for (int i = 0; i < 6; i++) begin
      g = i < qd.size() ? qd[i] : 24'hx;
      ge = i < qe.size() ? qe[i] : 1'bx;
      n_chk++; if (g !== ed[i]) begin n_fail++; $display("FAIL er_dout[%0d] got %h want %h", i, g, ed[i]); end
      n_chk++; if (ge !== (i == 2 || i == 5)) begin n_fail++; $display("FAIL er_eol[%0d] got %b want %b", i, ge, i == 2 || i == 5); end
    end
  endtask
  task automatic test_one_pixel();
    sel4 = 1'b0; mode_erode = 1'b0; shape_square = 1'b0;
    qd.delete(); qe.delete();
    px(24'h333333, 24'h333333, 24'h333333, 1'b1);
    idle(5);
    n_chk++; if (qd.size() != 1) begin n_fail++; $display("FAIL one_count got %0d want 1", qd.size()); end
    n_chk++; if (qd.size() > 0 && qd[0] !== 24'h333333) begin n_fail++; $display("FAIL one_dout got %h want 333333", qd[0]); end
    n_chk++; if (qe.size() > 0 && qe[0] !== 1'b1) begin n_fail++; $display("FAIL one_eol got %b want 1", qe[0]); end
    n_chk++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL one_fill got %b want 1", b.in_ready); end
  endtask
  task automatic test_forced_flush();
    logic [23:0] ed [6] = '{24'd60, 24'd60, 24'd50, 24'd40, 24'd20, 24'd20};
    logic [23:0] g;
    logic ge;
    sel4 = 1'b1; mode_erode = 1'b0; shape_square = 1'b0;
    qd4.delete(); qe4.delete();
    for (int i = 0; i < 4; i++) px(24'h0, 24'((6 - i) * 10), 24'h0, 1'b0);
    n_chk++; if (b4.in_ready !== 1'b0) begin n_fail++; $display("FAIL ff_ready got %b want 0", b4.in_ready); end
    px(24'h0, 24'd20, 24'h0, 1'b0);
    px(24'h0, 24'd10, 24'h0, 1'b1);
    idle(6);
    n_chk++; if (qd4.size() != 6) begin n_fail++; $display("FAIL ff_count got %0d want 6", qd4.size()); end
    for (int i = 0; i < 6; i++) begin
      g = i < qd4.size() ? qd4[i] : 24'hx;
      ge = i < qe4.size() ? qe4[i] : 1'bx;
      n_chk++; if (g !== ed[i]) begin n_fail++; $display("FAIL ff_dout[%0d] got %h want %h", i, g, ed[i]); end
      n_chk++; if (ge !== (i == 3 || i == 5)) begin n_fail++; $display("FAIL ff_eol[%0d] got %b want %b", i, ge, i == 3 || i == 5); end
    end
    sel4 = 1'b0;
  endtask
  task automatic test_reset_and_mode();
    logic [23:0] ed [6] = '{24'h141414, 24'h1E1E1E, 24'h1E1E1E, 24'h0A0A0A, 24'h0A0A0A, 24'h141414};
    logic [23:0] g;
    sel4 = 1'b0; mode_erode = 1'b0; shape_square = 1'b0;
    px(24'h505050, 24'h505050, 24'h505050, 1'b0);
    px(24'h606060, 24'h606060, 24'h606060, 1'b0);
    px(24'h707070, 24'h707070, 24'h707070, 1'b0);
    n_chk++; if (b.valid_out !== 1'b1 || b.dout !== 24'h606060) begin n_fail++; $display("FAIL rm_pre got v=%b d=%h want v=1 d=606060", b.valid_out, b.dout); end
    rst = 1'b1;
    idle(1);
    n_chk++; if (b.valid_out !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b want 0", b.valid_out); end
    n_chk++; if (b.dout !== 24'h0) begin n_fail++; $display("FAIL rm_dout got %h want 000000", b.dout); end
    n_chk++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %b want 1", b.in_ready); end
    rst = 1'b0;
    qd.delete(); qe.delete();
    idle(4);
    n_chk++; if (qd.size() != 0) begin n_fail++; $display("FAIL rm_stale got %0d outputs want 0", qd.size()); end
    px(24'h0A0A0A, 24'h0A0A0A, 24'h0A0A0A, 1'b0);
    mode_erode = 1'b1;
    px(24'h141414, 24'h141414, 24'h141414, 1'b0);
    px(24'h1E1E1E, 24'h1E1E1E, 24'h1E1E1E, 1'b1);
    px(24'h0A0A0A, 24'h0A0A0A, 24'h0A0A0A, 1'b0);
    px(24'h141414, 24'h141414, 24'h141414, 1'b0);
    px(24'h1E1E1E, 24'h1E1E1E, 24'h1E1E1E, 1'b1);
    idle(6);
    n_chk++; if (qd.size() != 6) begin n_fail++; $display("FAIL rm_count got %0d want 6", qd.size()); end
    for (int i = 0; i < 6; i++) begin
      g = i < qd.size() ? qd[i] : 24'hx;
      n_chk++; if (g !== ed[i]) begin n_fail++; $display("FAIL rm_dout[%0d] got %h want %h", i, g, ed[i]); end
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_dilate_cross();
    test_channels();
    test_back_to_back_erode();
    test_one_pixel();
    test_forced_flush();
    test_reset_and_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
